// File: rtl/alu_step_ctrl_if.sv
// Board-side bundle for the ALU step stage:
// switches and step button in, LED word and status out.
interface alu_step_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] sw;
    logic             step;
    logic [WIDTH-1:0] led;
    logic [2:0]       stage;
    logic             result_valid;

    modport master (
        output sw, step,
        input  led, stage, result_valid
    );

    modport slave (
        input  sw, step,
        output led, stage, result_valid
    );
endinterface

// File: rtl/alu_step_ctrl.sv
// Step-button sequencer for A, B, opcode, result and flags,
// with a registered ALU and registered LED word.
module alu_step_ctrl #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    alu_step_ctrl_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_B   = 3'd1,
        S_OP  = 3'd2,
        S_RES = 3'd3,
        S_FLG = 3'd4
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   pulse;

    logic [WIDTH-1:0] a, a_n;
    logic [WIDTH-1:0] b, b_n;
    logic [3:0]       op, op_n;
    logic [WIDTH-1:0] res, res_n;
    logic [3:0]       flg, flg_n;
    logic [WIDTH-1:0] led_q, led_n;
    logic             rv_q, rv_n;

    logic [3:0]              opc;
    logic [WIDTH:0]          add_w;
    logic [WIDTH:0]          sub_w;
    logic [SW-1:0]           sh;
    logic [2*WIDTH-1:0]      dbl;
    logic signed [WIDTH-1:0] sra_w;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_c;
    logic                    alu_v;

    assign opc   = bus.sw[3:0];
    assign pulse = sync[SYNC_STAGES-1] & ~prev;

    // Synchronize the async button and keep the previous level for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.step};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};
    assign sh    = b[SW-1:0];
    assign dbl   = {a, a} << sh;
    assign sra_w = $signed(a) >>> sh;

    // ALU result and carry/overflow for the opcode on the switches
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opc)
            4'd0: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2:    alu_res = a & b;
            4'd3:    alu_res = a | b;
            4'd4:    alu_res = a ^ b;
            4'd5:    alu_res = ~a;
            4'd6:    alu_res = a << sh;
            4'd7:    alu_res = a >> sh;
            4'd8:    alu_res = sra_w;
            4'd9:    alu_res = dbl[2*WIDTH-1:WIDTH];
            default: alu_res = '0;
        endcase
    end

    // Next state and latched values, advancing only on a step pulse
    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        op_n    = op;
        res_n   = res;
        flg_n   = flg;
        case (state)
            S_A: if (pulse) begin
                a_n     = bus.sw;
                state_n = S_B;
            end
            S_B: if (pulse) begin
                b_n     = bus.sw;
                state_n = S_OP;
            end
            S_OP: if (pulse) begin
                op_n    = opc;
                res_n   = alu_res;
                flg_n   = {alu_c, alu_res == '0,
                           alu_res[WIDTH-1], alu_v};
                state_n = S_RES;
            end
            S_RES: if (pulse) state_n = S_FLG;
            S_FLG: if (pulse) state_n = S_A;
            default: state_n = S_A;
        endcase
    end

    // LED word and status for the state being entered
    always_comb begin
        led_n = '0;
        rv_n  = 1'b0;
        case (state_n)
            S_A:   led_n = a_n;
            S_B:   led_n = b_n;
            S_OP:  led_n[3:0] = op_n;
            S_RES: begin
                led_n = res_n;
                rv_n  = 1'b1;
            end
            S_FLG: begin
                led_n[3:0] = flg_n;
                rv_n       = 1'b1;
            end
            default: led_n = '0;
        endcase
    end

    // Register state, operands, result and display
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_A;
            a     <= '0;
            b     <= '0;
            op    <= '0;
            res   <= '0;
            flg   <= '0;
            led_q <= '0;
            rv_q  <= 1'b0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            op    <= op_n;
            res   <= res_n;
            flg   <= flg_n;
            led_q <= led_n;
            rv_q  <= rv_n;
        end
    end

    assign bus.led          = led_q;
    assign bus.stage        = state;
    assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_alu_step_ctrl.sv
// Scoreboard bench for alu_step_ctrl: stimulus pushes expected
// displays, a monitor pops them whenever the stage changes.
module tb_alu_step_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_step_ctrl_if #(.WIDTH(16)) bus ();

    alu_step_ctrl #(
        .WIDTH(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [2:0]  st;
        logic [15:0] led;
        logic        rv;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    bit   mon_en = 1'b0;
    logic [2:0] last_st;

    int mst, ma, mb, mop, mres, mc, mz, mn, mv;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic void ref_alu(input int a, input int b,
                                    input int op);
        int sa, sb, s, t;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        s  = b % 16;
        mres = 0;
        mc = 0;
        mv = 0;
        case (op)
            0: begin
                t = a + b;
                mres = t % 65536;
                mc = t / 65536;
                mv = int'((sa + sb > 32767) || (sa + sb < -32768));
            end
            1: begin
                mres = (a - b + 65536) % 65536;
                mc = int'(a < b);
                mv = int'((sa - sb > 32767) || (sa - sb < -32768));
            end
            2: mres = a & b;
            3: mres = a | b;
            4: mres = a ^ b;
            5: mres = 65535 - a;
            6: mres = (a * (2 ** s)) % 65536;
            7: mres = a / (2 ** s);
            8: begin
                t = sa >>> s;
                mres = (t + 65536) % 65536;
            end
            9: mres = (a * (2 ** s)) % 65536 + a / (2 ** (16 - s));
            default: mres = 0;
        endcase
        mz = int'(mres == 0);
        mn = int'(mres >= 32768);
    endfunction

    function automatic void model_reset();
        mst = 0; ma = 0; mb = 0; mop = 0;
        mres = 0; mc = 0; mz = 0; mn = 0; mv = 0;
    endfunction

    function automatic void model_pulse(input int swv);
        exp_t e;
        case (mst)
            0: begin ma = swv; mst = 1; end
            1: begin mb = swv; mst = 2; end
            2: begin
                mop = swv % 16;
                ref_alu(ma, mb, mop);
                mst = 3;
            end
            3: mst = 4;
            default: mst = 0;
        endcase
        e.st = 3'(mst);
        e.rv = (mst == 3 || mst == 4);
        case (mst)
            0: e.led = 16'(ma);
            1: e.led = 16'(mb);
            2: e.led = 16'(mop);
            3: e.led = 16'(mres);
            default: e.led = 16'(mc * 8 + mz * 4 + mn * 2 + mv);
        endcase
        q.push_back(e);
    endfunction

    // Pop and compare on every stage change
    always @(negedge clk) begin : mon
        exp_t e;
        if (!mon_en) begin
            last_st = bus.stage;
        end else if (bus.stage !== last_st) begin
            last_st = bus.stage;
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_advance: got stage %0d expected none",
                         bus.stage);
            end else begin
                e = q.pop_front();
                chk("mon_stage", bus.stage, e.st);
                chk("mon_led", bus.led, e.led);
                chk("mon_rv", bus.result_valid, e.rv);
                chk("mon_stage_range", bus.stage <= 3'd4, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int v, input int hold);
        bus.sw = 16'(v);
        model_pulse(v);
        bus.step = 1'b1;
        repeat (hold) tick();
        bus.step = 1'b0;
        repeat (4) tick();
    endtask

    task automatic run_seq(input int a, input int b, input int op,
                           input int eres, input int eflg);
        press(a, 1);
        press(b, 2);
        press(op, 3);
        chk("res_led", bus.led, eres);
        chk("res_valid", bus.result_valid, 1);
        press(int'($urandom_range(0, 65535)), 1);
        chk("flg_led", bus.led, eflg);
        chk("flg_valid", bus.result_valid, 1);
        press(int'($urandom_range(0, 65535)), 2);
    endtask

    initial begin
        exp_t e;
        int v;
        rst = 1'b1;
        bus.step = 1'b0;
        bus.sw = '0;
        model_reset();
        repeat (3) tick();
        chk("rst_stage", bus.stage, 0);
        chk("rst_led", bus.led, 0);
        chk("rst_valid", bus.result_valid, 0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();

        run_seq(16'h7FFF, 16'h0001, 0, 16'h8000, 16'h0003);
        run_seq(16'h0003, 16'h0005, 1, 16'hFFFE, 16'h000A);
        run_seq(16'h8001, 16'h0004, 8, 16'hF800, 16'h0002);
        run_seq(16'h8001, 16'h0004, 9, 16'h0018, 16'h0000);
        run_seq(16'h8001, 16'h0004, 7, 16'h0800, 16'h0000);
        run_seq(16'h8001, 16'h0004, 12, 16'h0000, 16'h0004);

        v = 16'h1234;
        bus.sw = 16'(v);
        model_pulse(v);
        bus.step = 1'b1;
        tick();
        tick();
        chk("no_early_update", bus.stage, 0);
        tick();
        chk("third_edge_update", bus.stage, 1);
        repeat (47) tick();
        bus.step = 1'b0;
        tick();
        v = 16'h00A5;
        bus.sw = 16'(v);
        model_pulse(v);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        repeat (5) tick();
        chk("held_two_advances", bus.stage, 2);
        press(0, 1);
        chk("in_res", bus.stage, 3);

        bus.step = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        model_reset();
        e.st = 3'd0;
        e.led = 16'd0;
        e.rv = 1'b0;
        q.push_back(e);
        tick();
        chk("rst_pulse_stage", bus.stage, 0);
        chk("rst_pulse_led", bus.led, 0);
        chk("rst_pulse_valid", bus.result_valid, 0);
        rst = 1'b0;
        bus.step = 1'b0;
        repeat (4) tick();
        press(16'h5A5A, 1);
        chk("b_cleared", bus.led, 0);
        press(16'h0003, 1);
        press(1, 1);
        press(0, 1);
        press(0, 1);

        for (int i = 0; i < 60; i++) begin
            press(int'($urandom_range(0, 65535)),
                  int'($urandom_range(1, 5)));
        end

        repeat (10) tick();
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_step_ctrl.md
Name: alu_step_ctrl

Overview:
- Operand/opcode sequencer and registered ALU for the board-level ALU test stage.
- Steps through operand A, operand B, opcode, result and flags, one push of the step button per stage.
- Data comes from the DIP switches; the LEDs show the latched value or result.
- Consumes the raw step button and switches, and produces the LED word that the board top-level drives out.

Parameters:
WIDTH, 16, datapath width of operands, result and LED word (minimum 8)
SYNC_STAGES, 2, flip-flops in the step-input synchronizer (minimum 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sw  input  WIDTH  switch data (operand value, or opcode in sw[3:0])
step  input  1  step button, active-high, debounced externally, asynchronous to clk
led  output  WIDTH  displayed value
stage  output  3  current FSM state encoding
result_valid  output  1  high while result or flags are displayed

Behaviour:
Reset:
- rst sampled high at a clk edge: state=S_A, A=B=0, OP=0, RES=0, flags C/Z/N/V=0.
- Outputs after that edge: led=0, stage=0, result_valid=0.
- rst overrides any step edge in the same cycle.
- rst mid-sequence discards all latched values.

Step input and edge detection:
- step passes through SYNC_STAGES flops, then one more "previous" flop.
- step_pulse = sync_out & ~prev. It is one clk cycle wide per rising edge.
- Holding step high gives exactly one pulse. A release/re-press is required for the next pulse.
- With SYNC_STAGES=2, the register/state update occurs at the 3rd rising clk edge after step rises.

FSM (stage encoding in parentheses); all transitions happen only on step_pulse, otherwise the state holds:
- S_A (0): led=A. Pulse: A<=sw, go S_B.
- S_B (1): led=B. Pulse: B<=sw, go S_OP.
- S_OP (2): led={zeros, OP}. Pulse: OP<=sw[3:0]; RES and flags are computed from A, B, sw[3:0] and registered at the same edge; go S_RES.
- S_RES (3): led=RES, result_valid=1. Pulse: go S_FLG.
- S_FLG (4): led={zeros, C, Z, N, V} (C at bit 3, V at bit 0), result_valid=1. Pulse: go S_A.
- A, B, RES and flags are retained when the sequence returns to S_A, so the next run starts from the displayed old A.
- Encodings 5-7 are unreachable; if ever entered, go to S_A on the next edge.

Operations (width WIDTH, modulo 2^WIDTH; shift amount s = B[3:0], or B[log2(WIDTH)-1:0] in general):
- 0 ADD: A+B. C=carry out. V=signed overflow.
- 1 SUB: A-B. C=borrow (1 iff A<B unsigned). V=signed overflow.
- 2 AND, 3 OR, 4 XOR: bitwise.
- 5 NOT: ~A.
- 6 SLL: A<<s.
- 7 SRL: A>>s, logical.
- 8 SRA: A>>>s, arithmetic.
- 9 ROL: A rotated left by s. s=0 gives A.
- 10-15: RES=0.
- Flags: Z=(RES==0), N=RES[WIDTH-1] for all opcodes. C and V are 0 for every opcode except ADD and SUB.
- Opcodes 10-15 therefore give Z=1, N=0, C=0, V=0.

Output timing:
- led, stage and result_valid are registered or decoded from registered state only, so they are glitch-free.
- They update on the edge that changes the state.

Test Plan:
- Reset, then A=0x7FFF, B=0x0001, op=0 (ADD) -> S_RES: led=0x8000; S_FLG: led=0x0003 (C=0, Z=0, N=1, V=1); result_valid=1 in both.
- A=0x0003, B=0x0005, op=1 (SUB) -> RES=0xFFFE; flags C=1, Z=0, N=1, V=0 -> led=0x000A.
- A=0x8001, B=0x0004: op=8 (SRA) -> 0xF800; op=9 (ROL) -> 0x0018; op=7 (SRL) -> 0x0800; op=12 -> RES=0, flags led=0x0004.
- step held high for 50 cycles, then a 1-cycle glitch-free re-press -> exactly two state advances; the first update lands at the 3rd edge after the rise.
- rst asserted in S_RES simultaneously with a step pulse -> next cycle stage=0, led=0, result_valid=0, A=B=0.
- Full cycle S_A..S_FLG..S_A, then 5 more pulses with new switches -> correct recomputation; stage never leaves 0-4.
